// File: rtl/osc_capture_ctrl.sv
// Capture sequencer for the two-channel scope path: decimates A/B samples into a
// circular RAM with pre-trigger depth, level/edge trigger and post-trigger fill.
module osc_capture_ctrl #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic                ad_clk,
    input  logic                sys_rst,
    input  logic                arm,
    input  logic                force_trig,
    input  logic                rd_ack,
    input  logic                trig_src,
    input  logic                trig_edge,
    input  logic [DATA_W-1:0]   trig_level,
    input  logic [15:0]         decim,
    input  logic [ADDR_W-1:0]   pretrig,
    input  logic [DATA_W-1:0]   adc_data_A,
    input  logic [DATA_W-1:0]   adc_data_B,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_waddr,
    output logic [2*DATA_W-1:0] ram_wdata,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   trig_addr,
    output logic [ADDR_W-1:0]   start_addr
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t              r_state;
    logic                r_src, r_edge;
    logic [DATA_W-1:0]   r_level;
    logic [15:0]         r_decim, r_dcnt;
    logic [ADDR_W-1:0]   r_pretrig, r_wptr, r_cnt;
    logic [DATA_W-1:0]   r_prev;
    logic                r_prev_vld, r_fpend, r_last;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr, r_trig_addr, r_start_addr;
    logic [2*DATA_W-1:0] r_wdata;

    logic              w_cap, w_sen, w_wr, w_edge, w_trig;
    logic [DATA_W-1:0] w_cur;
    logic [ADDR_W-1:0] w_post_n;

    assign w_cap    = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_sen    = w_cap && (r_dcnt == r_decim);
    // r_last marks that the final sample is already in the write register
    assign w_wr     = w_sen && !r_last;
    assign w_cur    = r_src ? adc_data_B : adc_data_A;
    assign w_edge   = r_prev_vld && (r_edge ? (r_prev >= r_level && w_cur <  r_level)
                                            : (r_prev <  r_level && w_cur >= r_level));
    assign w_trig   = (r_state == S_WAIT) && w_wr && (r_fpend || force_trig || w_edge);
    assign w_post_n = ~r_pretrig;

    always_ff @(posedge ad_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_src        <= 1'b0;
            r_edge       <= 1'b0;
            r_level      <= '0;
            r_decim      <= '0;
            r_dcnt       <= '0;
            r_pretrig    <= '0;
            r_wptr       <= '0;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_prev_vld   <= 1'b0;
            r_fpend      <= 1'b0;
            r_last       <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
        end else if (arm) begin
            r_state      <= (pretrig == '0) ? S_WAIT : S_PRE;
            r_src        <= trig_src;
            r_edge       <= trig_edge;
            r_level      <= trig_level;
            r_decim      <= decim;
            r_pretrig    <= pretrig;
            r_dcnt       <= '0;
            r_wptr       <= '0;
            r_cnt        <= '0;
            r_prev_vld   <= 1'b0;
            r_fpend      <= 1'b0;
            r_last       <= 1'b0;
            r_we         <= 1'b0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
        end else begin
            r_we <= w_wr;
            if (w_wr) begin
                r_waddr <= r_wptr;
                r_wdata <= {adc_data_A, adc_data_B};
                r_wptr  <= r_wptr + 1'b1;
            end
            if (w_cap)
                r_dcnt <= w_sen ? 16'd0 : r_dcnt + 16'd1;

            case (r_state)
                S_PRE: if (w_wr) begin
                    if (r_cnt == r_pretrig - 1'b1) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (force_trig)
                        r_fpend <= 1'b1;
                    if (w_wr) begin
                        r_prev     <= w_cur;
                        r_prev_vld <= 1'b1;
                    end
                    if (w_trig) begin
                        r_trig_addr  <= r_wptr;
                        r_start_addr <= r_wptr - r_pretrig;
                        r_cnt        <= '0;
                        r_last       <= (w_post_n == '0);
                        r_fpend      <= 1'b0;
                        r_state      <= S_POST;
                    end
                end
                S_POST: begin
                    // Leave one clock after the last write so done trails it
                    if (r_last) begin
                        r_state <= S_DONE;
                    end else if (w_wr) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == w_post_n - 1'b1)
                            r_last <= 1'b1;
                    end
                end
                S_DONE: if (rd_ack) r_state <= S_IDLE;
                default: ;
            endcase
        end
    end

    assign ram_we     = r_we;
    assign ram_waddr  = r_waddr;
    assign ram_wdata  = r_wdata;
    assign busy       = w_cap;
    assign done       = (r_state == S_DONE);
    assign trig_addr  = r_trig_addr;
    assign start_addr = r_start_addr;
endmodule
